// File: rtl/s2_cfg_writer_if.sv
// s2 config writer: parallel word handshake
// from the network-programming controller.
interface s2_cfg_writer_if #(
  parameter int W = 16
) ();
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_abort;

  modport master (
    output cfg_data,
    output cfg_valid,
    output cfg_abort,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    input  cfg_abort,
    output cfg_ready
  );
endinterface

// File: rtl/s2_cfg_writer.sv
// s2 config writer: shifts a chain word MSB-first
// onto the cell config chain, then strobes latch.
module s2_cfg_writer #(
  parameter int NCELLS = 4,
  parameter int CFG_W  = 4
) (
  input  logic             clk,
  input  logic             clr,
  s2_cfg_writer_if.slave   cfg,
  output logic             sdo,
  output logic             sen,
  output logic             cfg_latch,
  output logic             done
);
  localparam int TOTAL = NCELLS * CFG_W;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t           state, state_n;
  logic [TOTAL-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sdo_n, sen_n;
  logic             latch_n, done_n;

  // ready is the only combinational output
  assign cfg.cfg_ready = (state == IDLE);

  // next state and next registered outputs
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    sdo_n   = 1'b0;
    sen_n   = 1'b0;
    latch_n = 1'b0;
    done_n  = done;
    unique case (state)
      IDLE: begin
        if (cfg.cfg_valid) begin
          state_n = SHIFT;
          shreg_n = cfg.cfg_data;
          cnt_n   = '0;
          done_n  = 1'b0;
          sen_n   = 1'b1;
          sdo_n   = cfg.cfg_data[TOTAL-1];
        end
      end
      SHIFT: begin
        if (cfg.cfg_abort) begin
          state_n = IDLE;
          shreg_n = '0;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = LATCH;
          shreg_n = '0;
          cnt_n   = '0;
          latch_n = 1'b1;
        end else begin
          shreg_n = {shreg[TOTAL-2:0], 1'b0};
          cnt_n   = cnt + 1'b1;
          sen_n   = 1'b1;
          sdo_n   = shreg_n[TOTAL-1];
        end
      end
      LATCH: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      sdo       <= 1'b0;
      sen       <= 1'b0;
      cfg_latch <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      sdo       <= sdo_n;
      sen       <= sen_n;
      cfg_latch <= latch_n;
      done      <= done_n;
    end
  end
endmodule

// File: doc/s2_cfg_writer.md
Name: s2_cfg_writer

Overview:
- Configuration writer for a chain of s2 logic cells: the driving end of the cell's d[3:0] truth-bit interface.
- Accepts one parallel configuration word for the whole chain over a valid/ready handshake.
- Shifts the word MSB-first onto a serial config chain, then pulses a latch strobe so every cell transfers its shifted bits into its d inputs together.
- Sits between the network-programming controller and the s2 cell array.

Parameters:
- NCELLS, 4, number of s2 cells in the chain.
- CFG_W, 4, config bits per cell (the d width).
- TOTAL (localparam), NCELLS*CFG_W, total bits shifted per load.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-low; clr=0 resets immediately, independent of clk.
- cfg_data  input  TOTAL  parallel configuration. Bits [CFG_W*k+CFG_W-1 : CFG_W*k] are d[3:0] of cell k.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  writer is idle and can accept a word.
- cfg_abort  input  1  cancels a shift in progress.
- sdo  output  1  serial config data to the chain.
- sen  output  1  shift enable to the chain.
- cfg_latch  output  1  one-cycle strobe: chain copies its shift bits into d.
- done  output  1  chain holds a completely latched configuration.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, shift register=0, counter=0.
  - sdo=0, sen=0, cfg_latch=0, done=0, cfg_ready=1.
  - Reset during SHIFT or LATCH discards the load; no latch pulse is issued.
- All outputs are registered except cfg_ready, which is decoded from state (1 only in IDLE).
- Counter width is clog2(TOTAL+1). It counts 0..TOTAL-1 and never wraps within a load.
- State IDLE:
  - sen=0, cfg_latch=0.
  - cfg_valid=1 at an edge: capture cfg_data into the shift register, counter=0, done=0, go to SHIFT.
  - cfg_abort is ignored in IDLE.
- State SHIFT:
  - Lasts exactly TOTAL cycles. In each cycle sen=1 and sdo=current shreg[TOTAL-1].
  - At each edge: shreg shifts left with 0 fill, counter increments.
  - At the edge where the counter equals TOTAL-1, go to LATCH.
  - Shift order: cfg_data[TOTAL-1] first, cfg_data[0] last. After TOTAL shifts, cell 0's bits sit nearest sdo and cell NCELLS-1's bits sit deepest in the chain.
  - cfg_valid is ignored while not in IDLE; cfg_data changes during SHIFT have no effect.
- State LATCH:
  - Lasts one cycle: cfg_latch=1, sen=0, sdo=0.
  - Next edge: go to IDLE with done=1.
- cfg_abort=1 at an edge while in SHIFT:
  - Go to IDLE, sen=0 from the next cycle, no cfg_latch, done stays 0.
  - Abort takes priority over the SHIFT-to-LATCH transition on the same edge.
  - Abort asserted during the LATCH cycle is ignored; the latch completes.
- Timing: acceptance edge at E0.
  - sen=1 during cycles E0+1 through E0+TOTAL.
  - cfg_latch=1 during cycle E0+TOTAL+1.
  - cfg_ready=1 and done=1 from cycle E0+TOTAL+2.
  - Back-to-back loads: a new word can be accepted at the first edge in IDLE. Its acceptance clears done at that edge.
- sdo is 0 whenever sen=0.
- sen and cfg_latch are never high in the same cycle.

Test Plan:
- Reset: hold clr=0 mid-shift, then release → sdo=0, sen=0, cfg_latch=0, done=0, cfg_ready=1 immediately (asynchronously), before any clock edge.
- Basic load (NCELLS=4), cfg_data=16'hA5C3, cfg_valid one cycle → cfg_ready drops next cycle; sen=1 for exactly 16 cycles.
  - sdo sequence: 1,0,1,0, 0,1,0,1, 1,1,0,0, 0,0,1,1.
  - cfg_latch=1 for one cycle at E0+17; done=1 and cfg_ready=1 at E0+18.
  - Model chain of 4 s2 cells then shows d = 4'h3, 4'hC, 4'h5, 4'hA for cells 0..3.
- Busy handling: drive cfg_valid=1 with cfg_data=16'hFFFF throughout a load of 16'h0001 → only 16'h0001 is shifted (15 zeros then a 1). The second word is accepted at the first IDLE edge, and done clears there.
- Abort: cfg_abort=1 at the 5th SHIFT edge → sen low next cycle, no cfg_latch ever pulses, done=0, cfg_ready=1. A subsequent load of 16'h1234 completes normally.
- Abort on the final SHIFT edge (counter=15) → no cfg_latch, state IDLE. Abort during the LATCH cycle → cfg_latch still pulses, done=1.
- Back-to-back: three words 16'h0000, 16'hFFFF, 16'h8001 with cfg_valid held high → exactly three latch pulses, 18 cycles apart. No cycle has sen and cfg_latch both high.
